// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - Operation encodings driven on pc_unit.op by the control FSM.
//   - clog2: ceiling log2, used for RAS pointer/count widths and the
//     alignment mask. clog2(1) is 0, so callers that need a non-zero
//     width must guarantee an argument of at least 2.
package pc_pkg;

  localparam logic [2:0] OP_HOLD   = 3'd0;
  localparam logic [2:0] OP_INC    = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL   = 3'd4;
  localparam logic [2:0] OP_RET    = 3'd5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: return-address stack implemented as a circular LIFO.
//   A push when full overwrites the oldest entry, so the newest RAS_DEPTH
//   return addresses are always retained.
//
// Ports:
//   clk        rising-edge clock
//   flush      synchronous clear of the stack (used as its reset)
//   push       write push_data on top (has priority over pop)
//   pop        remove the top entry (ignored when empty)
//   push_data  address to push
//   top_data   current top entry (meaningless when empty)
//   count      number of valid entries, 0..RAS_DEPTH
//   full       registered, count == RAS_DEPTH
//   empty      registered, count == 0
//   ovf        combinational event: push while full
//   unf        combinational event: pop while empty
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              push_data,
  output logic [WIDTH-1:0]              top_data,
  output logic [clog2(RAS_DEPTH+1)-1:0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          ovf,
  output logic                          unf
);

  localparam int PTR_W = clog2(RAS_DEPTH);
  localparam int CNT_W = clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [WIDTH-1:0] mem_d [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  // wr_ptr points at the next free slot; the top entry sits one below it,
  // wrapping explicitly so non-power-of-two depths work too.
  assign top_ptr  = (wr_ptr_q == '0) ? LAST_PTR : wr_ptr_q - PTR_ONE;
  assign top_data = mem_q[top_ptr];

  assign ovf = push & full_q;
  assign unf = pop & ~push & empty_q;

  // When full, wr_ptr also points at the oldest entry, so a plain push
  // overwrites it and only the count saturates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_ONE;
      if (!full_q) begin
        count_d = count_q + CNT_ONE;
      end
    end else if (pop && !empty_q) begin
      wr_ptr_d = top_ptr;
      count_d  = count_q - CNT_ONE;
    end
    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  // Entry contents need no reset; only pointer, count and flags are cleared.
  always_ff @(posedge clk) begin
    mem_q    <= mem_d;
    wr_ptr_q <= wr_ptr_d;
    count_q  <= count_d;
    full_q   <= full_d;
    empty_q  <= empty_d;
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter for the multi-cycle CPU with increment, jump,
// PC-relative branch, stall and a call/return address stack.
//
// Optional build macro: PC_ALIGN_CHECK_EN
//   Defined   - JUMP/CALL targets, BRANCH results and popped RET addresses
//               with nonzero low log2(STEP) bits pulse misalign (also sets
//               ras_err) and load with those bits cleared.
//   Undefined - misalign stays 0 and addresses load verbatim.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   stall      freeze pc and RAS; pulse outputs drop to 0
//   op         0 HOLD, 1 INC, 2 JUMP, 3 BRANCH, 4 CALL, 5 RET, 6/7 HOLD
//   target     absolute address for JUMP and CALL
//   offset     two's-complement displacement for BRANCH
//   pc         current program counter (registered)
//   ras_empty  RAS holds no entries
//   ras_full   RAS holds RAS_DEPTH entries
//   ras_ovf    pulse: CALL while full (oldest entry overwritten)
//   ras_unf    pulse: RET while empty (pc falls through to pc+STEP)
//   ras_err    sticky OR of ovf/unf (and misalign), cleared by rst only
//   misalign   pulse: misaligned load (always 0 without the macro)
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 1,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] offset,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf,
  output logic             ras_err,
  output logic             misalign
);

  localparam int               CNT_W  = clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             err_q, err_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] next_raw;
  logic [WIDTH-1:0] next_fixed;
  logic             chk_align;
  logic             mis_now;
  logic             ras_push;
  logic             ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty_w;
  logic             ras_full_w;
  logic             ras_ovf_ev;
  logic             ras_unf_ev;
  logic [CNT_W-1:0] ras_count_unused;

  assign seq_pc = pc_q + STEP_W;

  // The stack is cleared by the same synchronous reset as the pc, so a CALL
  // or RET coinciding with rst never survives.
  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .flush     (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .count     (ras_count_unused),
    .full      (ras_full_w),
    .empty     (ras_empty_w),
    .ovf       (ras_ovf_ev),
    .unf       (ras_unf_ev)
  );

  // Next-pc selection. Stall leaves everything at its held value and issues
  // no stack traffic. chk_align marks loads that come from an address
  // source rather than sequential increment.
  always_comb begin
    next_raw  = pc_q;
    chk_align = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    if (!stall) begin
      case (op)
        OP_INC: begin
          next_raw = seq_pc;
        end
        OP_JUMP: begin
          next_raw  = target;
          chk_align = 1'b1;
        end
        OP_BRANCH: begin
          next_raw  = pc_q + offset;
          chk_align = 1'b1;
        end
        OP_CALL: begin
          next_raw  = target;
          chk_align = 1'b1;
          ras_push  = 1'b1;
        end
        OP_RET: begin
          ras_pop = 1'b1;
          if (!ras_empty_w) begin
            next_raw  = ras_top;
            chk_align = 1'b1;
          end else begin
            next_raw = seq_pc;
          end
        end
        default: begin
          next_raw = pc_q;
        end
      endcase
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // With STEP=1 the mask is zero and this logic reduces to a pass-through.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  assign mis_now    = chk_align && ((next_raw & ALIGN_MASK) != '0);
  assign next_fixed = chk_align ? (next_raw & ~ALIGN_MASK) : next_raw;
`else
  logic align_unused;

  assign align_unused = chk_align;
  assign mis_now      = 1'b0;
  assign next_fixed   = next_raw;
`endif

  // Pulses are registered event flags; ras_err accumulates them on the
  // same edge they are raised.
  always_comb begin
    pc_d  = next_fixed;
    ovf_d = ras_ovf_ev;
    unf_d = ras_unf_ev;
    mis_d = mis_now;
    err_d = err_q | ras_ovf_ev | ras_unf_ev | mis_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      err_q <= err_d;
      mis_q <= mis_d;
    end
  end

  assign pc        = pc_q;
  assign ras_empty = ras_empty_w;
  assign ras_full  = ras_full_w;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
  assign ras_err   = err_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit. Two instances share clock and reset:
//   dut  - WIDTH=16, STEP=1, RAS_DEPTH=4, RESET_VEC=0 (main behaviour)
//   dut2 - same but STEP=2, used for increment step and alignment checks
// Each directed vector queues its hand-computed expected outputs; a monitor
// pops and compares them two time units after the edge that applies them.
module tb_pc_unit;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] target = 16'h0;
  logic [15:0] offset = 16'h0;
  logic [15:0] pc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf, ras_err, misalign;

  logic [2:0]  op2 = 3'd0;
  logic [15:0] target2 = 16'h0;
  logic [15:0] pc2;
  logic        ras_empty2, ras_full2, ras_ovf2, ras_unf2, ras_err2, misalign2;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [15:0] J2_PC  = 16'h0102;
  localparam logic [15:0] I2_PC  = 16'h0104;
  localparam logic        J2_MIS = 1'b1;
  localparam logic        A2_ERR = 1'b1;
`else
  localparam logic [15:0] J2_PC  = 16'h0103;
  localparam logic [15:0] I2_PC  = 16'h0105;
  localparam logic        J2_MIS = 1'b0;
  localparam logic        A2_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] pc;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
    logic        err;
    logic        mis;
    logic [15:0] pc2;
    logic        mis2;
    logic        err2;
  } obs_t;

  typedef struct {
    obs_t  exp;
    int    due;
    string name;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_item;
  int  cycle_cnt = 0;
  int  n_compared = 0;
  int  n_mismatched = 0;

  always #5 clk = ~clk;

  pc_unit #(
    .WIDTH     (16),
    .STEP      (1),
    .RAS_DEPTH (4),
    .RESET_VEC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .op        (op),
    .target    (target),
    .offset    (offset),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .ras_err   (ras_err),
    .misalign  (misalign)
  );

  pc_unit #(
    .WIDTH     (16),
    .STEP      (2),
    .RAS_DEPTH (4),
    .RESET_VEC (16'h0000)
  ) dut2 (
    .clk       (clk),
    .rst       (rst),
    .stall     (1'b0),
    .op        (op2),
    .target    (target2),
    .offset    (16'h0000),
    .pc        (pc2),
    .ras_empty (ras_empty2),
    .ras_full  (ras_full2),
    .ras_ovf   (ras_ovf2),
    .ras_unf   (ras_unf2),
    .ras_err   (ras_err2),
    .misalign  (misalign2)
  );

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input sb_t it);
    obs_t act;
    act = '{pc: pc, empty: ras_empty, full: ras_full, ovf: ras_ovf,
            unf: ras_unf, err: ras_err, mis: misalign,
            pc2: pc2, mis2: misalign2, err2: ras_err2};
    n_compared++;
    if (act !== it.exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got pc=%h emp=%b full=%b ovf=%b unf=%b err=%b mis=%b pc2=%h mis2=%b err2=%b; want pc=%h emp=%b full=%b ovf=%b unf=%b err=%b mis=%b pc2=%h mis2=%b err2=%b",
               it.name, act.pc, act.empty, act.full, act.ovf, act.unf, act.err, act.mis,
               act.pc2, act.mis2, act.err2,
               it.exp.pc, it.exp.empty, it.exp.full, it.exp.ovf, it.exp.unf, it.exp.err,
               it.exp.mis, it.exp.pc2, it.exp.mis2, it.exp.err2);
    end
  endtask

  // Monitor: outputs settle after the edge; compare every due expectation.
  always @(posedge clk) begin
    #2;
    while (sb_q.size() > 0 && sb_q[0].due <= cycle_cnt) begin
      mon_item = sb_q.pop_front();
      checkOutput(mon_item);
    end
  end

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the next rising edge.
  task automatic applyStimulus(
    input string       name,
    input logic        r,
    input logic        s,
    input logic [2:0]  o,
    input logic [15:0] tgt,
    input logic [15:0] off,
    input logic [15:0] e_pc,
    input logic        e_empty,
    input logic        e_full,
    input logic        e_ovf,
    input logic        e_unf,
    input logic        e_err,
    input logic [2:0]  o2     = 3'd0,
    input logic [15:0] tgt2   = 16'h0000,
    input logic [15:0] e_pc2  = 16'h0000,
    input logic        e_mis2 = 1'b0,
    input logic        e_err2 = 1'b0
  );
    sb_t it;
    @(negedge clk);
    rst     = r;
    stall   = s;
    op      = o;
    target  = tgt;
    offset  = off;
    op2     = o2;
    target2 = tgt2;
    it.exp  = '{pc: e_pc, empty: e_empty, full: e_full, ovf: e_ovf, unf: e_unf,
                err: e_err, mis: 1'b0, pc2: e_pc2, mis2: e_mis2, err2: e_err2};
    it.due  = cycle_cnt + 1;
    it.name = name;
    sb_q.push_back(it);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //            name          rst   stall op         target    offset    pc        emp  full ovf  unf  err
    applyStimulus("reset",      1'b1, 1'b0, OP_HOLD,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("inc1",       1'b0, 1'b0, OP_INC,    16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("inc2",       1'b0, 1'b0, OP_INC,    16'h0000, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("inc3",       1'b0, 1'b0, OP_INC,    16'h0000, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("jump_ffff",  1'b0, 1'b0, OP_JUMP,   16'hFFFF, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("inc_wrap",   1'b0, 1'b0, OP_INC,    16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("jump_0010",  1'b0, 1'b0, OP_JUMP,   16'h0010, 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("branch_neg", 1'b0, 1'b0, OP_BRANCH, 16'h0000, 16'hFFF0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("branch_pos", 1'b0, 1'b0, OP_BRANCH, 16'h0000, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("jump_0100",  1'b0, 1'b0, OP_JUMP,   16'h0100, 16'h0000, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("call_0200",  1'b0, 1'b0, OP_CALL,   16'h0200, 16'h0000, 16'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("call_0300",  1'b0, 1'b0, OP_CALL,   16'h0300, 16'h0000, 16'h0300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ret_0201",   1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h0201, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ret_0101",   1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Five calls into a 4-deep stack: the fifth overwrites the 0x0102 entry.
    applyStimulus("call5_1",    1'b0, 1'b0, OP_CALL,   16'h1000, 16'h0000, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("call5_2",    1'b0, 1'b0, OP_CALL,   16'h2000, 16'h0000, 16'h2000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("call5_3",    1'b0, 1'b0, OP_CALL,   16'h3000, 16'h0000, 16'h3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("call5_4",    1'b0, 1'b0, OP_CALL,   16'h4000, 16'h0000, 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus("call5_ovf",  1'b0, 1'b0, OP_CALL,   16'h5000, 16'h0000, 16'h5000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("ret5_1",     1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h4001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ret5_2",     1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h3001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ret5_3",     1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h2001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ret5_4",     1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("ret5_unf",   1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus("hold_after", 1'b0, 1'b0, OP_HOLD,   16'h0000, 16'h0000, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("op6_hold",   1'b0, 1'b0, 3'd6,      16'h7777, 16'h0001, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("op7_hold",   1'b0, 1'b0, 3'd7,      16'h7777, 16'h0001, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("stall_c1",   1'b0, 1'b1, OP_CALL,   16'h0A00, 16'h0000, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("stall_c2",   1'b0, 1'b1, OP_CALL,   16'h0A00, 16'h0000, 16'h1002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("stall_rel",  1'b0, 1'b0, OP_CALL,   16'h0A00, 16'h0000, 16'h0A00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus("rst_call",   1'b1, 1'b0, OP_CALL,   16'h0B00, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("ret_postrst",1'b0, 1'b0, OP_RET,    16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus("reset2",     1'b1, 1'b0, OP_HOLD,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // STEP=2 instance: misaligned jump, then a sequential increment.
    applyStimulus("align_jump", 1'b0, 1'b0, OP_HOLD,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  OP_JUMP, 16'h0103, J2_PC, J2_MIS, A2_ERR);
    applyStimulus("align_inc",  1'b0, 1'b0, OP_HOLD,   16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                  OP_INC, 16'h0000, I2_PC, 1'b0, A2_ERR);

    @(negedge clk);
    op  = OP_HOLD;
    op2 = OP_HOLD;
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb_q.size() > 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
